// File: rtl/alarm_controller.sv
// Alarm sequencer: BCD alarm edit, time match, ring with auto-timeout and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (adds the SNOOZE state and snooze_p handling).
module alarm_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       clk_set_en,
  input  logic       edit_p,
  input  logic       inc_p,
  input  logic       arm_p,
  input  logic       snooze_p,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_edit,
  output logic [1:0] blink_sel,
  output logic       armed,
  output logic       ring,
  output logic       snooze_active
);

`ifdef ALARM_SNOOZE_EN
  localparam int CNT_MAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
`else
  localparam int CNT_MAX = RING_TIMEOUT_SEC;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_RING = CW'(RING_TIMEOUT_SEC);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] CNT_SNZ  = CW'(SNOOZE_SEC);
`endif

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    EDIT_HH  = 3'd2,
    EDIT_MM  = 3'd3,
`ifdef ALARM_SNOOZE_EN
    SNOOZE   = 3'd5,
`endif
    RINGING  = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          tick_d_r;
  logic [7:0]    alarm_hh_r;
  logic [7:0]    alarm_mm_r;
  logic          match_s;

  // Packed-BCD increment with wrap at max_val; inputs only ever hold valid BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val == max_val) begin
      res = 8'h00;
    end else if (val[3:0] == 4'h9) begin
      res = {val[7:4] + 4'h1, 4'h0};
    end else begin
      res = val + 8'h01;
    end
    return res;
  endfunction

`ifndef ALARM_SNOOZE_EN
  logic unused_s;
  assign unused_s = ^{snooze_p, SNOOZE_SEC[0]};
`endif

  // Compare runs one cycle after the tick, once the time counter has advanced.
  assign match_s = tick_d_r && !clk_set_en && (cur_hh == alarm_hh_r) &&
                   (cur_mm == alarm_mm_r) && (cur_ss == 8'h00);

  // Alarm FSM, alarm registers and shared ring/snooze seconds counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= DISARMED;
      cnt_r      <= '0;
      tick_d_r   <= 1'b0;
      alarm_hh_r <= 8'h00;
      alarm_mm_r <= 8'h00;
    end else begin
      tick_d_r <= tick_1hz;
      case (state_r)
        DISARMED: begin
          if (!clk_set_en) begin
            if (arm_p) begin
              state_r <= ARMED;
            end else if (edit_p) begin
              state_r <= EDIT_HH;
            end
          end
        end
        ARMED: begin
          if (!clk_set_en) begin
            if (arm_p) begin
              state_r <= DISARMED;
            end else if (edit_p) begin
              state_r <= EDIT_HH;
            end else if (match_s) begin
              state_r <= RINGING;
              cnt_r   <= CNT_RING;
            end
          end
        end
        EDIT_HH: begin
          if (arm_p) begin
            state_r <= DISARMED;
          end else if (edit_p) begin
            state_r <= EDIT_MM;
          end else if (inc_p) begin
            alarm_hh_r <= bcd_inc(alarm_hh_r, 8'h23);
          end
        end
        EDIT_MM: begin
          if (arm_p) begin
            state_r <= DISARMED;
          end else if (edit_p) begin
            state_r <= ARMED;
          end else if (inc_p) begin
            alarm_mm_r <= bcd_inc(alarm_mm_r, 8'h59);
          end
        end
        RINGING: begin
          if (arm_p) begin
            state_r <= ARMED;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_p) begin
            state_r <= SNOOZE;
            cnt_r   <= CNT_SNZ;
`endif
          end else if (tick_1hz) begin
            if (cnt_r == CNT_ONE) begin
              state_r <= ARMED;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (arm_p) begin
            state_r <= ARMED;
          end else if (tick_1hz) begin
            if (cnt_r == CNT_ONE) begin
              state_r <= RINGING;
              cnt_r   <= CNT_RING;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
`endif
        default: begin
          state_r <= DISARMED;
        end
      endcase
    end
  end

  assign alarm_hh   = alarm_hh_r;
  assign alarm_mm   = alarm_mm_r;
  assign alarm_edit = (state_r == EDIT_HH) || (state_r == EDIT_MM);
  assign ring       = (state_r == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign snooze_active = (state_r == SNOOZE);
  assign armed = (state_r == ARMED) || (state_r == RINGING) || (state_r == SNOOZE);
`else
  assign snooze_active = 1'b0;
  assign armed = (state_r == ARMED) || (state_r == RINGING);
`endif

  // Blink selection follows the field being edited.
  always_comb begin
    blink_sel = 2'b11;
    case (state_r)
      EDIT_HH: blink_sel = 2'b00;
      EDIT_MM: blink_sel = 2'b01;
      default: blink_sel = 2'b11;
    endcase
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller (SNOOZE_SEC=3, RING_TIMEOUT_SEC=5).
module tb_alarm_controller;
  logic       clk;
  logic       rst;
  logic       tick_1hz, clk_set_en, edit_p, inc_p, arm_p, snooze_p;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_edit, armed, ring, snooze_active;
  logic [1:0] blink_sel;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // {alarm_edit, armed, ring, snooze_active, blink_sel}
  localparam logic [5:0] S_DIS  = 6'b0000_11;
  localparam logic [5:0] S_ARM  = 6'b0100_11;
  localparam logic [5:0] S_EHH  = 6'b1000_00;
  localparam logic [5:0] S_EMM  = 6'b1000_01;
  localparam logic [5:0] S_RING = 6'b0110_11;
  localparam logic [5:0] S_SNZ  = 6'b0101_11;

  alarm_controller #(.SNOOZE_SEC(3), .RING_TIMEOUT_SEC(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .clk_set_en(clk_set_en),
    .edit_p(edit_p), .inc_p(inc_p), .arm_p(arm_p), .snooze_p(snooze_p),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_edit(alarm_edit),
    .blink_sel(blink_sel), .armed(armed), .ring(ring), .snooze_active(snooze_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; edit_p = 1'b0; inc_p = 1'b0; arm_p = 1'b0; snooze_p = 1'b0;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {alarm_edit, armed, ring, snooze_active, blink_sel};
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic pulse_n(input int n, input bit is_inc);
    for (int i = 0; i < n; i++) begin
      if (is_inc) inc_p = 1'b1; else tick_1hz = 1'b1;
      cyc();
    end
  endtask

  // Tick with cur at hh:mm:59, then advance cur to hh:mm:00; returns in the compare cycle.
  task automatic tick_to(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    cur_hh = hh; cur_mm = mm; cur_ss = 8'h59;
    tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    cur_ss = ss;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; clk_set_en = 1'b0; edit_p = 1'b0; inc_p = 1'b0;
    arm_p = 1'b0; snooze_p = 1'b0; cur_hh = 8'h00; cur_mm = 8'h00; cur_ss = 8'h01;
    cyc(); cyc();
    chk_st("reset_state", S_DIS);
    chk8("reset_hh", alarm_hh, 8'h00);
    chk8("reset_mm", alarm_mm, 8'h00);
    rst = 1'b0;
    cyc();

    // Edit and wrap
    edit_p = 1'b1; cyc();
    chk_st("edit_hh_state", S_EHH);
    pulse_n(10, 1'b1);
    chk8("hh_bcd_carry", alarm_hh, 8'h10);
    pulse_n(14, 1'b1);
    chk8("hh_wrap", alarm_hh, 8'h00);
    edit_p = 1'b1; cyc();
    chk_st("edit_mm_state", S_EMM);
    pulse_n(61, 1'b1);
    chk8("mm_wrap", alarm_mm, 8'h01);
    edit_p = 1'b1; cyc();
    chk_st("edit_exit_arms", S_ARM);

    // Set alarm to 07:30 (mm from 01 needs 29 steps)
    edit_p = 1'b1; cyc();
    pulse_n(7, 1'b1);
    edit_p = 1'b1; cyc();
    pulse_n(29, 1'b1);
    edit_p = 1'b1; cyc();
    chk8("set_hh", alarm_hh, 8'h07);
    chk8("set_mm", alarm_mm, 8'h30);

    // Non-zero seconds does not match
    tick_to(8'h07, 8'h30, 8'h01);
    cyc(); cyc();
    chk_st("no_match_ss01", S_ARM);

    // Match latency: ring two cycles after the tick
    tick_to(8'h07, 8'h30, 8'h00);
    chk8("ring_t1_low", {7'd0, ring}, 8'h00);
    cyc();
    chk_st("ring_t2_high", S_RING);
    cur_ss = 8'h01;

    // Auto-stop after 5 ticks
    pulse_n(4, 1'b0);
    chk_st("ring_after_4_ticks", S_RING);
    pulse_n(1, 1'b0);
    chk_st("autostop_armed", S_ARM);
    tick_to(8'h07, 8'h30, 8'h00);
    cyc();
    chk_st("next_day_rings", S_RING);
    cur_ss = 8'h01;

`ifdef ALARM_SNOOZE_EN
    snooze_p = 1'b1; cyc();
    chk_st("snooze_enter", S_SNZ);
    pulse_n(2, 1'b0);
    chk_st("snooze_after_2", S_SNZ);
    pulse_n(1, 1'b0);
    chk_st("snooze_to_ring", S_RING);
    pulse_n(4, 1'b0);
    chk_st("reload_after_4", S_RING);
    pulse_n(1, 1'b0);
    chk_st("reload_autostop", S_ARM);
    tick_to(8'h07, 8'h30, 8'h00);
    cyc();
    cur_ss = 8'h01;
    snooze_p = 1'b1; cyc();
    arm_p = 1'b1; cyc();
    chk_st("snooze_dismiss", S_ARM);
`else
    snooze_p = 1'b1; cyc();
    chk_st("snooze_ignored", S_RING);
    arm_p = 1'b1; cyc();
    chk_st("ring_dismiss", S_ARM);
`endif

    // Priority: arm_p beats snooze_p while ringing
    tick_to(8'h07, 8'h30, 8'h00);
    cyc();
    cur_ss = 8'h01;
    chk_st("prio_ringing", S_RING);
    arm_p = 1'b1; snooze_p = 1'b1; cyc();
    chk_st("prio_arm_wins", S_ARM);

    // Lockout
    clk_set_en = 1'b1;
    tick_to(8'h07, 8'h30, 8'h00);
    cyc(); cyc();
    chk_st("lockout_no_match", S_ARM);
    edit_p = 1'b1; cyc();
    chk_st("lockout_no_edit", S_ARM);
    clk_set_en = 1'b0;
    cur_ss = 8'h01;

    // Abort edit keeps value, then re-arm at 08:30
    edit_p = 1'b1; cyc();
    inc_p = 1'b1; cyc();
    arm_p = 1'b1; cyc();
    chk_st("abort_disarmed", S_DIS);
    chk8("abort_keeps_hh", alarm_hh, 8'h08);
    arm_p = 1'b1; cyc();
    chk_st("rearm", S_ARM);

    // Asynchronous reset mid-ring
    tick_to(8'h08, 8'h30, 8'h00);
    cyc();
    chk_st("ring_before_rst", S_RING);
    #2;
    rst = 1'b1;
    #1;
    chk8("async_ring_low", {7'd0, ring}, 8'h00);
    chk8("rst_hh", alarm_hh, 8'h00);
    chk8("rst_mm", alarm_mm, 8'h00);
    chk_st("rst_state", S_DIS);
    cyc();
    rst = 1'b0;
    cyc();
    chk_st("post_rst_state", S_DIS);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm sequencer for the digital clock. Holds a BCD alarm time (HH:MM), lets the user edit it through debounced button pulses, and compares it against the running BCD time. On a match it drives a ring output, with snooze, dismiss and auto-timeout. It sits beside the time counter and time-set logic, and feeds the display mux with the alarm value and blink selection while editing.

## Interface
- `SNOOZE_SEC`, default 300: snooze length in `tick_1hz` pulses, at least 1.
- `RING_TIMEOUT_SEC`, default 60: ring length before auto-stop, in `tick_1hz` pulses, at least 1.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick_1hz` in 1: one-cycle pulse on the cycle in which the time counter advances.
- `clk_set_en` in 1: the time-set logic owns the buttons; while high this block is locked out.
- `edit_p` in 1: one-cycle pulse that enters and steps alarm edit.
- `inc_p` in 1: one-cycle pulse that increments the field being edited.
- `arm_p` in 1: one-cycle pulse that toggles arm, or dismisses a ring or snooze.
- `snooze_p` in 1: one-cycle pulse that requests snooze.
- `cur_hh`, `cur_mm`, `cur_ss` in 8 each: current time, packed BCD.
- `alarm_hh`, `alarm_mm` out 8 each: alarm time, packed BCD.
- `alarm_edit` out 1: high in `EDIT_HH` and `EDIT_MM`; the display then shows `alarm_hh:alarm_mm`.
- `blink_sel` out 2: 2'b00 blinks HH, 2'b01 blinks MM, 2'b11 is no blink.
- `armed` out 1: high in `ARMED`, `RINGING` and `SNOOZE`.
- `ring` out 1: buzzer enable, high only in `RINGING`.
- `snooze_active` out 1: high only in `SNOOZE`.

## Operation
- States are `DISARMED`, `ARMED`, `EDIT_HH`, `EDIT_MM`, `RINGING` and `SNOOZE`. Reset state is `DISARMED`.
- Reset values:
  - `alarm_hh` = 8'h00, `alarm_mm` = 8'h00.
  - `blink_sel` = 2'b11.
  - `ring`, `armed`, `snooze_active` and `alarm_edit` all 0.
  - The seconds counter is 0.
- Button priority within one cycle: `arm_p` > `snooze_p` > `edit_p` > `inc_p`. Only the highest-priority applicable pulse acts; the rest are dropped.
- `DISARMED`:
  - `arm_p` goes to `ARMED`.
  - `edit_p` goes to `EDIT_HH`.
- `ARMED`:
  - `arm_p` goes to `DISARMED`.
  - `edit_p` goes to `EDIT_HH`.
  - A match goes to `RINGING` and loads the counter with `RING_TIMEOUT_SEC`.
- `EDIT_HH`:
  - `inc_p` increments `alarm_hh` in BCD, 8'h23 wraps to 8'h00.
  - `edit_p` goes to `EDIT_MM`.
  - `blink_sel` = 2'b00.
- `EDIT_MM`:
  - `inc_p` increments `alarm_mm` in BCD, 8'h59 wraps to 8'h00.
  - `edit_p` goes to `ARMED`; leaving edit always arms.
  - `blink_sel` = 2'b01.
- Edit-state exceptions:
  - `arm_p` in either edit state aborts to `DISARMED`; the edited value is kept.
  - `snooze_p` is ignored.
- `RINGING`:
  - `arm_p` (dismiss) goes to `ARMED`.
  - `snooze_p` goes to `SNOOZE` and loads `SNOOZE_SEC`.
  - Each `tick_1hz` decrements the counter. A tick while the counter is 1 goes to `ARMED` (auto-stop).
  - `edit_p` and `inc_p` are ignored.
- `SNOOZE`:
  - `arm_p` goes to `ARMED`.
  - Each tick decrements the counter. A tick while the counter is 1 goes to `RINGING` and reloads `RING_TIMEOUT_SEC`.
  - `snooze_p`, `edit_p` and `inc_p` are ignored.
- Match condition: registered `tick_d` is 1, `clk_set_en` is 0, `cur_hh == alarm_hh`, `cur_mm == alarm_mm` and `cur_ss == 8'h00`.
- `clk_set_en` lockout: while high, `edit_p`, `inc_p` and `arm_p` are ignored in `DISARMED` and `ARMED` and no match fires. `RINGING` and `SNOOZE` continue unaffected.
- Counter width is `$clog2(max(SNOOZE_SEC, RING_TIMEOUT_SEC) + 1)`.
- All outputs are registered or decoded from the state register only; there are no combinational paths from the inputs.

## Timing
- Match latency: `tick_1hz` high in cycle T means the counter updates at the end of T. `tick_d` and the compare happen in T+1, and `ring` is high from T+2.
- Button pulses act at the next rising edge; the output changes 1 cycle after the pulse.
- Asserting `rst` at any time forces the reset values immediately, including `ring` dropping low mid-ring without waiting for a clock edge.
- A `tick_1hz` and a button pulse in the same cycle: the button transition wins and the tick is not counted. A reloaded counter starts from the full value.

## Configuration
- `ALARM_SNOOZE_EN` defined: the `SNOOZE` state, the `SNOOZE_SEC` reload and the `snooze_p` handling are all present.
- `ALARM_SNOOZE_EN` undefined:
  - The `SNOOZE` state is not built; `snooze_p` is ignored everywhere and `snooze_active` is tied to 0.
  - `RINGING` exits only on `arm_p`, auto-stop or reset.
  - `SNOOZE_SEC` is unused, and the counter width uses `RING_TIMEOUT_SEC` only.

## Test plan
All scenarios use `SNOOZE_SEC` = 3 and `RING_TIMEOUT_SEC` = 5.
- Edit and wrap: from reset, `edit_p`, 24×`inc_p`, `edit_p`, 61×`inc_p`, `edit_p` gives `alarm_hh` = 8'h00, `alarm_mm` = 8'h01, state `ARMED`, and `blink_sel` sequence 00, 01, 11.
- Match latency: armed with alarm 07:30; drive `tick_1hz` with cur moving 07:29:59 → 07:30:00. `ring` rises exactly 2 cycles after the tick. A match with `cur_ss` = 8'h01 does not ring.
- Auto-stop: ringing, then 5 ticks. `ring` falls 1 cycle after the 5th tick, state `ARMED`, and the next day's match rings again.
- Snooze (macro on): ringing, `snooze_p`, then 3 ticks. `snooze_active` is high for 3 ticks, then `ring` is high again with the counter reloaded to 5. `arm_p` during `SNOOZE` gives `ARMED` with `ring` 0.
- Priority and lockout: `arm_p` and `snooze_p` in the same cycle while ringing gives `ARMED`, not `SNOOZE`. With `clk_set_en` = 1, a match and `edit_p` are both ignored.
- Reset mid-ring: assert `rst` while `ring` = 1. `ring` goes to 0 asynchronously, the alarm clears to 00:00, and the state is `DISARMED`.
